conv_channel_accum_param: RTL

//  Parametrised cross-channel partial-sum accumulator for the conv_1x1 datapath; successor to the fixed 128-channel adder.

---
 rtl/conv_channel_accum_param.sv | 104 ++++++++++
 1 files changed

// File: rtl/conv_channel_accum_param.sv
// conv_channel_accum_param: sums CHANNEL_NUM_IN partial-product planes per output channel,
// with optional stride-2 decimation, signed saturation and a frame-done pulse.
module conv_channel_accum_param #(
  parameter int DATA_WIDTH      = 16,
  parameter int GUARD_BITS      = 8,
  parameter int IMAGE_WIDTH     = 8,
  parameter int IMAGE_HEIGHT    = 8,
  parameter int CHANNEL_NUM_IN  = 4,
  parameter int CHANNEL_NUM_OUT = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid_in,
  input  logic signed [DATA_WIDTH-1:0] pxl_in,
  input  logic                         stride2,
  output logic signed [DATA_WIDTH-1:0] pxl_out,
  output logic                         valid_out,
  output logic                         frame_done
);
  localparam int AW     = DATA_WIDTH + GUARD_BITS;
  localparam int DEPTH  = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int CW     = $clog2(IMAGE_WIDTH);
  localparam int RW     = $clog2(IMAGE_HEIGHT);
  localparam int PW     = CHANNEL_NUM_IN > 1 ? $clog2(CHANNEL_NUM_IN) : 1;
  localparam int OW     = CHANNEL_NUM_OUT > 1 ? $clog2(CHANNEL_NUM_OUT) : 1;
  localparam int BW     = $clog2(DEPTH);
  localparam int KEPT_S = ((IMAGE_WIDTH + 1) / 2) * ((IMAGE_HEIGHT + 1) / 2);
  localparam logic signed [AW-1:0] MAXV = {{(GUARD_BITS + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = ~MAXV;

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [PW-1:0] r_plane;
  logic [OW-1:0] r_och;
  logic [BW-1:0] r_addr, r_a1;
  logic r_stride, r_v1, r_first1, r_last1, r_fd1;
  logic signed [DATA_WIDTH-1:0] r_d1;
  logic signed [AW-1:0] r_rd;
  logic signed [AW-1:0] r_mem [DEPTH];

  logic w_start, w_stride, w_keep, w_last_px;
  logic w_col_end, w_row_end, w_plane_end, w_och_end;
  logic signed [AW-1:0] w_sum;
  logic signed [DATA_WIDTH-1:0] w_sat;

  always_comb begin
    w_start     = r_col == '0 && r_row == '0 && r_plane == '0 && r_och == '0;
    w_stride    = w_start ? stride2 : r_stride;
    w_col_end   = r_col == CW'(IMAGE_WIDTH - 1);
    w_row_end   = r_row == RW'(IMAGE_HEIGHT - 1);
    w_plane_end = r_plane == PW'(CHANNEL_NUM_IN - 1);
    w_och_end   = r_och == OW'(CHANNEL_NUM_OUT - 1);
    w_keep      = valid_in && (!w_stride || (!r_row[0] && !r_col[0]));
    w_last_px   = r_addr == (w_stride ? BW'(KEPT_S - 1) : BW'(DEPTH - 1));
    w_sum       = (r_first1 ? '0 : r_rd) + AW'(r_d1);
    w_sat       = w_sum > MAXV ? MAXV[DATA_WIDTH-1:0] :
                  w_sum < MINV ? MINV[DATA_WIDTH-1:0] : w_sum[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col    <= '0;
      r_row    <= '0;
      r_plane  <= '0;
      r_och    <= '0;
      r_addr   <= '0;
      r_stride <= 1'b0;
    end else if (valid_in) begin
      r_col  <= w_col_end ? '0 : r_col + 1'b1;
      r_addr <= (w_col_end && w_row_end) ? '0 : r_addr + BW'(w_keep);
      if (w_start) r_stride <= stride2;
      if (w_col_end) r_row <= w_row_end ? '0 : r_row + 1'b1;
      if (w_col_end && w_row_end) r_plane <= w_plane_end ? '0 : r_plane + 1'b1;
      if (w_col_end && w_row_end && w_plane_end) r_och <= w_och_end ? '0 : r_och + 1'b1;
    end
  end

  // The first plane overwrites its slot, so the buffer never needs clearing.
  always_ff @(posedge clk) begin
    if (w_keep) begin
      r_rd     <= r_mem[r_addr];
      r_a1     <= r_addr;
      r_d1     <= pxl_in;
      r_first1 <= r_plane == '0;
      r_last1  <= w_plane_end;
      r_fd1    <= w_plane_end && w_och_end && w_last_px;
    end
    if (r_v1) r_mem[r_a1] <= w_sum;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1       <= 1'b0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      pxl_out    <= '0;
    end else begin
      r_v1       <= w_keep;
      valid_out  <= r_v1 && r_last1;
      frame_done <= r_v1 && r_last1 && r_fd1;
      if (r_v1 && r_last1) pxl_out <= w_sat;
    end
  end
endmodule
